// File: rtl/register_skid_ctrl.sv
// Two-entry skid-buffer valid/ready stage with fully registered s_ready, m_valid and m_data.
// Optional stall counter output enabled by defining REGISTER_SKID_STALL_CNT_EN.
module register_skid_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       occupancy
`ifdef REGISTER_SKID_STALL_CNT_EN
    ,
    output logic [31:0]      stall_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             s_ready_q, m_valid_q;
    logic [1:0]       occ_q, occ_d;
    logic             xfer_in, xfer_out;

    assign xfer_in  = s_valid & s_ready_q;
    assign xfer_out = m_valid_q & m_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        // flush drops everything held; out_q keeps its stale value
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (xfer_in) begin
                    out_d   = s_data;
                    state_d = BUSY;
                end
                BUSY: begin
                    if (xfer_in && xfer_out) begin
                        out_d = s_data;
                    end else if (xfer_in) begin
                        skid_d  = s_data;
                        state_d = FULL;
                    end else if (xfer_out) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (xfer_out) begin
                    out_d   = skid_q;
                    state_d = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
        case (state_d)
            BUSY:    occ_d = 2'd1;
            FULL:    occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            s_ready_q <= (state_d != FULL);
            m_valid_q <= (state_d != EMPTY);
            occ_q     <= occ_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = out_q;
    assign occupancy = occ_q;

`ifdef REGISTER_SKID_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (flush)
            stall_d = '0;
        else if (m_valid_q && !m_ready && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif

endmodule
